// File: rtl/amiga_joy_bridge.sv
// amiga_joy_bridge
//   Input bridge from the MEGA65 controller front-end to the Minimig _joyN inputs.
//   Per bit: two-flop synchroniser, then a debouncer timed in 7 MHz enable ticks.
//   Per channel: optional autofire on FIRE_BIT, port-1/port-2 swap, change strobe.
//
// Ports:
//   i_clk          system clock (28.37516 MHz)
//   i_rst_ext      asynchronous active-high reset
//   i_clk7_en      7 MHz enable, timebase for debounce and autofire
//   i_joy_in       raw buttons, active high, channel c at [c*WIDTH +: WIDTH]
//   i_db_limit     debounce length in enable ticks, 0 = no debounce
//   i_af_period    autofire half-period in enable ticks, 0 = autofire off
//   i_autofire_en  per-channel autofire enable
//   i_swap12       exchange channels 0 and 1 at the output
//   o_ami_joy_n    registered, active-low joystick words (1 = released)
//   o_changed      one-cycle strobe per channel when its output word changed
module amiga_joy_bridge #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DB_BITS  = 8,
    parameter int unsigned FIRE_BIT = 4   // must be < WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_ext,
    input  logic                       i_clk7_en,
    input  logic [CHANNELS*WIDTH-1:0]  i_joy_in,
    input  logic [DB_BITS-1:0]         i_db_limit,
    input  logic [15:0]                i_af_period,
    input  logic [CHANNELS-1:0]        i_autofire_en,
    input  logic                       i_swap12,
    output logic [CHANNELS*WIDTH-1:0]  o_ami_joy_n,
    output logic [CHANNELS-1:0]        o_changed
);

    localparam int unsigned NBITS = CHANNELS * WIDTH;

    logic [NBITS-1:0]   r_s1;
    logic [NBITS-1:0]   r_s2;
    logic [NBITS-1:0]   r_stable;
    logic [DB_BITS-1:0] r_cnt [NBITS];
    logic [15:0]        r_pc;
    logic               r_ph;
    logic [NBITS-1:0]   r_ami_joy_n;
    logic [CHANNELS-1:0] r_changed;

    logic [NBITS-1:0]    w_stable_d;
    logic [DB_BITS-1:0]  w_cnt_d [NBITS];
    logic [DB_BITS-1:0]  w_db_last;
    logic                w_db_on;
    logic                w_af_on;
    logic [WIDTH-1:0]    w_proc [CHANNELS];
    logic [NBITS-1:0]    w_mapped;
    logic [NBITS-1:0]    w_out_d;
    logic [CHANNELS-1:0] w_changed_d;

    assign w_db_on   = (i_db_limit != '0);
    assign w_db_last = i_db_limit - DB_BITS'(1);
    assign w_af_on   = (i_af_period != 16'd0);

    // Synchroniser: free-running, no enable.
    always_ff @(posedge i_clk or posedge i_rst_ext) begin
        if (i_rst_ext) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_joy_in;
            r_s2 <= r_s1;
        end
    end

    // Debounce: a bit must disagree with its stable value for db_limit ticks in a
    // row; any agreement in between throws the count away.
    always_comb begin
        w_stable_d = r_stable;
        for (int b = 0; b < int'(NBITS); b++) begin
            w_cnt_d[b] = r_cnt[b];
            if (r_s2[b] == r_stable[b]) begin
                w_cnt_d[b] = '0;
            end else if (!w_db_on) begin
                w_stable_d[b] = r_s2[b];
                w_cnt_d[b]    = '0;
            end else if (i_clk7_en) begin
                if (r_cnt[b] == w_db_last) begin
                    w_stable_d[b] = r_s2[b];
                    w_cnt_d[b]    = '0;
                end else begin
                    w_cnt_d[b] = r_cnt[b] + DB_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_ext) begin
        if (i_rst_ext) begin
            r_stable <= '0;
            r_cnt    <= '{default: '0};
        end else begin
            r_stable <= w_stable_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // Autofire prescaler. ph restarts at 1 so a held fire is seen pressed first.
    always_ff @(posedge i_clk or posedge i_rst_ext) begin
        if (i_rst_ext) begin
            r_pc <= 16'd0;
            r_ph <= 1'b1;
        end else if (!w_af_on) begin
            r_pc <= 16'd0;
            r_ph <= 1'b1;
        end else if (i_clk7_en) begin
            if (r_pc == i_af_period - 16'd1) begin
                r_pc <= 16'd0;
                r_ph <= ~r_ph;
            end else begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

    // Per-channel autofire gating of the fire bit.
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_proc[c] = r_stable[c*WIDTH +: WIDTH];
            if (i_autofire_en[c] && w_af_on) begin
                w_proc[c][FIRE_BIT] = r_stable[c*WIDTH + FIRE_BIT] & r_ph;
            end
        end
    end

    // Port mapping; only channels 0 and 1 can be exchanged.
    always_comb begin
        w_mapped = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_mapped[c*WIDTH +: WIDTH] = w_proc[c];
        end
        if (i_swap12) begin
            w_mapped[0 +: WIDTH]     = w_proc[1];
            w_mapped[WIDTH +: WIDTH] = w_proc[0];
        end
        w_out_d = ~w_mapped;
    end

    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_changed_d[c] = (w_out_d[c*WIDTH +: WIDTH] != r_ami_joy_n[c*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_ext) begin
        if (i_rst_ext) begin
            r_ami_joy_n <= '1;
            r_changed   <= '0;
        end else begin
            r_ami_joy_n <= w_out_d;
            r_changed   <= w_changed_d;
        end
    end

    assign o_ami_joy_n = r_ami_joy_n;
    assign o_changed   = r_changed;

endmodule

// File: tb/tb_amiga_joy_bridge.sv
// tb_amiga_joy_bridge
//   Self-checking bench for amiga_joy_bridge: directed vector table, hand-written
//   multi-cycle sequences (reset, debounce, autofire, swap, parameter sweep) and a
//   randomized run against a behavioural reference model.
module tb_amiga_joy_bridge;

    localparam int FB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] joy;
    logic [7:0]  db;
    logic [15:0] af;
    logic [3:0]  afen;
    logic        swap;
    logic [63:0] out;
    logic [3:0]  chg;

    logic        en2;
    logic [15:0] joy2;
    logic [3:0]  db2;
    logic [15:0] out2;
    logic [1:0]  chg2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    amiga_joy_bridge #(
        .CHANNELS(4),
        .WIDTH   (16),
        .DB_BITS (8),
        .FIRE_BIT(4)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_ext    (rst),
        .i_clk7_en    (en),
        .i_joy_in     (joy),
        .i_db_limit   (db),
        .i_af_period  (af),
        .i_autofire_en(afen),
        .i_swap12     (swap),
        .o_ami_joy_n  (out),
        .o_changed    (chg)
    );

    amiga_joy_bridge #(
        .CHANNELS(2),
        .WIDTH   (8),
        .DB_BITS (4),
        .FIRE_BIT(4)
    ) u_dut2 (
        .i_clk        (clk),
        .i_rst_ext    (rst),
        .i_clk7_en    (en2),
        .i_joy_in     (joy2),
        .i_db_limit   (db2),
        .i_af_period  (16'd0),
        .i_autofire_en(2'b00),
        .i_swap12     (1'b0),
        .o_ami_joy_n  (out2),
        .o_changed    (chg2)
    );

    // Reference model state (main instance only).
    logic [63:0] m_s1, m_s2, m_st, m_out;
    logic [3:0]  m_chg;
    int          m_cnt [64];
    int          m_pc;
    bit          m_ph;
    logic [15:0] low_acc;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_out = '1; m_chg = '0;
        for (int b = 0; b < 64; b++) m_cnt[b] = 0;
        m_pc = 0; m_ph = 1'b1;
    endtask

    task automatic model_step();
        logic [15:0] w [4];
        logic [63:0] nout;
        logic [3:0]  nchg;
        int          src;
        for (int c = 0; c < 4; c++) begin
            w[c] = m_st[c*16 +: 16];
            if (afen[c] && af != 0) w[c][FB] = w[c][FB] & m_ph;
        end
        for (int c = 0; c < 4; c++) begin
            src = (swap && c < 2) ? 1 - c : c;
            nout[c*16 +: 16] = ~w[src];
            nchg[c] = (nout[c*16 +: 16] != m_out[c*16 +: 16]);
        end
        for (int b = 0; b < 64; b++) begin
            if (m_s2[b] == m_st[b]) m_cnt[b] = 0;
            else if (db == 0) begin
                m_st[b] = m_s2[b];
                m_cnt[b] = 0;
            end else if (en) begin
                if (m_cnt[b] == int'(db) - 1) begin
                    m_st[b] = m_s2[b];
                    m_cnt[b] = 0;
                end else m_cnt[b] = (m_cnt[b] + 1) % 256;
            end
        end
        if (af == 0) begin
            m_pc = 0;
            m_ph = 1'b1;
        end else if (en) begin
            if (m_pc == int'(af) - 1) begin
                m_pc = 0;
                m_ph = ~m_ph;
            end else m_pc = (m_pc + 1) % 65536;
        end
        m_s2 = m_s1;
        m_s1 = joy;
        m_out = nout;
        m_chg = nchg;
    endtask

    // One clock: model advances on the edge, outputs are then sampled #1 later.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        low_acc = low_acc | ~out[15:0];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sw;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [15:0] j2;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [5];
    int   b;
    logic [63:0] e64;

    initial begin
        tbl[0] = '{1'b0, 16'h0001, 16'h0010, 16'h8000, 64'hFFFF_7FFF_FFEF_FFFE};
        tbl[1] = '{1'b1, 16'h0001, 16'h0010, 16'h8000, 64'hFFFF_7FFF_FFFE_FFEF};
        tbl[2] = '{1'b0, 16'hA5A5, 16'h0F0F, 16'h1234, 64'hFFFF_EDCB_F0F0_5A5A};
        tbl[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 64'hFFFF_FFFF_0000_FFFF};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF};

        rst = 1'b1; en = 1'b0; joy = '0; db = '0; af = '0; afen = '0; swap = 1'b0;
        en2 = 1'b1; joy2 = '0; db2 = 4'd15; low_acc = '0;
        model_reset();
        repeat (3) cyc();

        // Reset behaviour
        rst = 1'b0; joy = '1;
        repeat (6) cyc();
        check("pre_reset_out", out, 64'h0);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_out", out, '1);
        check("async_rst_chg", 64'(chg), 64'h0);
        rst = 1'b0;
        repeat (3) cyc();
        check("rel_3clk_out", out, '1);
        cyc();
        check("rel_4clk_out", out, 64'h0);
        check("rel_4clk_chg", 64'(chg), 64'hF);
        cyc();
        check("rel_5clk_chg", 64'(chg), 64'h0);

        // Vector table, no debounce, no autofire
        for (int i = 0; i < 5; i++) begin
            joy  = {16'h0000, tbl[i].j2, tbl[i].j1, tbl[i].j0};
            swap = tbl[i].sw;
            repeat (4) cyc();
            check($sformatf("table_%0d", i), out, tbl[i].exp);
        end

        // Swap toggle strobes both channels
        joy = {32'h0, 16'h0010, 16'h0001}; swap = 1'b0;
        repeat (5) cyc();
        check("swap_pre", out, 64'hFFFF_FFFF_FFEF_FFFE);
        swap = 1'b1;
        cyc();
        check("swap_out", out, 64'hFFFF_FFFF_FFFE_FFEF);
        check("swap_chg", 64'(chg), 64'h3);
        cyc();
        check("swap_chg_once", 64'(chg), 64'h0);
        swap = 1'b0; joy = '0;
        repeat (5) cyc();

        // Debounce: a 2-tick pulse then a 1-tick pulse must both be rejected
        db = 8'd3; low_acc = '0;
        joy = 64'h4; repeat (3) cyc();
        en = 1'b1; cyc(); en = 1'b0; cyc(); en = 1'b1; cyc(); en = 1'b0;
        joy = 64'h0; repeat (3) cyc();
        joy = 64'h4; repeat (3) cyc();
        en = 1'b1; cyc(); en = 1'b0;
        joy = 64'h0; repeat (4) cyc();
        check("db_short_pulse", 64'(low_acc), 64'h0);
        // Held for three ticks
        joy = 64'h4; repeat (3) cyc();
        en = 1'b1; cyc(); en = 1'b0; cyc();
        en = 1'b1; cyc(); en = 1'b0; cyc();
        en = 1'b1; cyc(); en = 1'b0;
        check("db_3rd_tick", 64'(out[15:0]), 64'hFFFF);
        cyc();
        check("db_out", 64'(out[15:0]), 64'hFFFB);
        check("db_chg", 64'(chg), 64'h1);
        cyc();
        check("db_chg_once", 64'(chg), 64'h0);
        joy = '0; db = '0;
        repeat (5) cyc();

        // Autofire on channel 1, fire held on channels 0 and 1
        af = 16'd5; afen = 4'b0010; joy = 64'h0010_0010;
        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        repeat (4) cyc();
        check("af_start", 64'(out[31:0]), 64'hFFEF_FFEF);
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            e64 = (((k - 1) / 5) % 2 == 1) ? 64'hFFFF_FFEF : 64'hFFEF_FFEF;
            check($sformatf("af_out_k%0d", k), 64'(out[31:0]), e64);
            check($sformatf("af_chg_k%0d", k), 64'(chg), (k == 6 || k == 11) ? 64'h2 : 64'h0);
        end

        // Autofire off globally: fire passes straight through
        af = 16'd0; afen = 4'hF; joy = 64'h0010_0010_0010_0010;
        for (int k = 0; k < 16; k++) begin
            en = ($urandom % 2 == 0);
            cyc();
            if (k >= 4) check($sformatf("afoff_k%0d", k), out, {4{16'hFFEF}});
        end
        // Re-enable: ph must still be 1 and pc 0, so three ticks pressed then released
        af = 16'd3; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("af_restart_k%0d", k), out,
                  (k == 4) ? {4{16'hFFFF}} : {4{16'hFFEF}});
        end
        af = '0; afen = '0; joy = '0; en = 1'b0;
        repeat (5) cyc();

        // Parameter sweep instance: 2 x 8 bits, db_limit 15, enable every cycle
        joy2 = 16'h3C81;
        repeat (17) cyc();
        check("p2_before", 64'(out2), 64'hFFFF);
        cyc();
        check("p2_out", 64'(out2), 64'hC37E);
        check("p2_chg", 64'(chg2), 64'h3);

        // Randomized run against the reference model
        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 6 == 0) begin
                b = $urandom_range(63, 0);
                joy[b] = ~joy[b];
            end
            if ($urandom % 10 == 0) joy = joy ^ (64'h0010_0010_0010_0010 & {$urandom, $urandom});
            if ($urandom % 97 == 0) joy = {$urandom, $urandom};
            en = ($urandom % 3 == 0);
            if ($urandom % 200 == 0) db = 8'($urandom % 5);
            if ($urandom % 150 == 0) af = 16'($urandom % 7);
            if ($urandom % 100 == 0) afen = 4'($urandom);
            if ($urandom % 40 == 0) swap = ~swap;
            if (i == 1500) begin
                rst = 1'b1; #1; model_reset();
                check("rnd_rst_out", out, '1);
                rst = 1'b0;
            end
            cyc();
            check($sformatf("rnd_out_%0d", i), out, m_out);
            check($sformatf("rnd_chg_%0d", i), 64'(chg), 64'(m_chg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
